ahb_timer_slave: RTL and testbench

AHB3-Lite responder implementing a general-purpose 32-bit timer peripheral with a prescaler, a programmable period, a match flag and a level interrupt. It is instantiated once per timer slot on the tm0/tm1 ports of the data-bus multiplexer. It answers single NONSEQ transfers with a fixed one-cycle data phase. HREADY is asserted only for the data phase of an accepted transfer, because the multiplexer uses HREADY as read-valid and as its read-data select.

---
 rtl/ahb_timer_slave.sv | 159 +++++++++++++++
 tb/tb_ahb_timer_slave.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/ahb_timer_slave.sv
// AHB3-Lite timer peripheral: prescaler, 32-bit up-counter with period match, level irq.
// Define TMR_PWM_EN to add the CMP register (offset 5) and a registered PWM output.
module ahb_timer_slave #(
  parameter int          ADDR_W   = 32,
  parameter int          PRESC_W  = 16,
  parameter logic [31:0] RST_LOAD = 32'hFFFF_FFFF
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [31:0]       HWDATA,
  output logic [31:0]       HRDATA,
  output logic              HREADY,
  output logic              HRESP,
  output logic              irq,
  output logic              pwm_o
);

  localparam logic [2:0] OFF_CTRL   = 3'd0;
  localparam logic [2:0] OFF_PRESC  = 3'd1;
  localparam logic [2:0] OFF_LOAD   = 3'd2;
  localparam logic [2:0] OFF_COUNT  = 3'd3;
  localparam logic [2:0] OFF_STATUS = 3'd4;
  localparam logic [2:0] OFF_CMP    = 3'd5;

  // Data-phase context captured at the end of the address phase
  logic               dp_vld_q, dp_vld_d;
  logic               dp_wr_q,  dp_wr_d;
  logic [2:0]         dp_off_q, dp_off_d;

  logic [2:0]         ctrl_q,  ctrl_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [31:0]        load_q,  load_d;
  logic [31:0]        count_q, count_d;
  logic [PRESC_W-1:0] pcnt_q,  pcnt_d;
  logic               match_q, match_d;
  logic               irq_q,   irq_d;
  logic [31:0]        cmp_q,   cmp_d;
  logic               pwm_q,   pwm_d;

  logic               mapped;
  logic               wr_ctrl, wr_presc, wr_load, wr_status, wr_cmp;
  logic               tick, hw_match;
  logic [31:0]        rd_mux;

  logic unused_bits;
  assign unused_bits = ^{HTRANS[0], HADDR[ADDR_W-1:5], HADDR[1:0]};

  always_comb begin
    mapped = (dp_off_q <= OFF_STATUS);
`ifdef TMR_PWM_EN
    mapped = mapped | (dp_off_q == OFF_CMP);
`endif
  end

  assign dp_vld_d = HSEL & HTRANS[1];
  assign dp_wr_d  = HWRITE;
  assign dp_off_d = HADDR[4:2];

  // Bus writes commit at the edge ending the data phase
  assign wr_ctrl   = dp_vld_q & dp_wr_q & (dp_off_q == OFF_CTRL);
  assign wr_presc  = dp_vld_q & dp_wr_q & (dp_off_q == OFF_PRESC);
  assign wr_load   = dp_vld_q & dp_wr_q & (dp_off_q == OFF_LOAD);
  assign wr_status = dp_vld_q & dp_wr_q & (dp_off_q == OFF_STATUS);
`ifdef TMR_PWM_EN
  assign wr_cmp    = dp_vld_q & dp_wr_q & (dp_off_q == OFF_CMP);
`else
  assign wr_cmp    = 1'b0;
`endif

  // >= keeps the prescaler from running the long way round after PRESC is lowered
  assign tick     = ctrl_q[0] & (pcnt_q >= presc_q);
  assign hw_match = tick & (count_q == load_q);

  always_comb begin
    ctrl_d  = ctrl_q;
    presc_d = presc_q;
    load_d  = load_q;
    count_d = count_q;
    pcnt_d  = pcnt_q;
    cmp_d   = cmp_q;
    if (ctrl_q[0]) begin
      pcnt_d = tick ? '0 : pcnt_q + PRESC_W'(1);
      if (tick) count_d = hw_match ? 32'd0 : count_q + 32'd1;
      if (hw_match && ctrl_q[2]) ctrl_d[0] = 1'b0;
    end
    if (wr_ctrl)  ctrl_d  = HWDATA[2:0];
    if (wr_presc) presc_d = HWDATA[PRESC_W-1:0];
    if (wr_load) begin
      load_d  = HWDATA;
      count_d = '0;
      pcnt_d  = '0;
    end
    if (wr_cmp)   cmp_d   = HWDATA;
    match_d = (match_q & ~(wr_status & HWDATA[0])) | hw_match;
    irq_d   = match_q & ctrl_q[1];
    pwm_d   = ctrl_q[0] & (count_q < cmp_q);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      dp_vld_q <= 1'b0;
      dp_wr_q  <= 1'b0;
      dp_off_q <= '0;
      ctrl_q   <= '0;
      presc_q  <= '0;
      load_q   <= RST_LOAD;
      count_q  <= '0;
      pcnt_q   <= '0;
      match_q  <= 1'b0;
      irq_q    <= 1'b0;
      cmp_q    <= '0;
      pwm_q    <= 1'b0;
    end else begin
      dp_vld_q <= dp_vld_d;
      dp_wr_q  <= dp_wr_d;
      dp_off_q <= dp_off_d;
      ctrl_q   <= ctrl_d;
      presc_q  <= presc_d;
      load_q   <= load_d;
      count_q  <= count_d;
      pcnt_q   <= pcnt_d;
      match_q  <= match_d;
      irq_q    <= irq_d;
      cmp_q    <= cmp_d;
      pwm_q    <= pwm_d;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (dp_off_q)
      OFF_CTRL:   rd_mux = {29'd0, ctrl_q};
      OFF_PRESC:  rd_mux = 32'(presc_q);
      OFF_LOAD:   rd_mux = load_q;
      OFF_COUNT:  rd_mux = count_q;
      OFF_STATUS: rd_mux = {31'd0, match_q};
`ifdef TMR_PWM_EN
      OFF_CMP:    rd_mux = cmp_q;
`endif
      default:    rd_mux = '0;
    endcase
  end

  // HREADY doubles as read-valid for the bus mux, so it only pulses in data phases
  assign HREADY = dp_vld_q;
  assign HRESP  = dp_vld_q & ~mapped;
  assign HRDATA = (dp_vld_q & ~dp_wr_q & mapped) ? rd_mux : 32'd0;
  assign irq    = irq_q;
`ifdef TMR_PWM_EN
  assign pwm_o  = pwm_q;
`else
  assign pwm_o  = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_timer_slave.sv
// Directed testbench for ahb_timer_slave; exercises the PWM path when TMR_PWM_EN is defined.
module tb_ahb_timer_slave;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic        irq;
  logic        pwm_o;

  int checks = 0;
  int errors = 0;

  ahb_timer_slave #(.ADDR_W(32), .PRESC_W(16), .RST_LOAD(32'hFFFF_FFFF)) dut (
    .Clk(Clk), .Rst(Rst), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY),
    .HRESP(HRESP), .irq(irq), .pwm_o(pwm_o)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HADDR = 32'd0;
  endtask

  task automatic bus_wr(input int off, input logic [31:0] d, input logic exp_resp, input string tag);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'(off * 4);
    step();
    bus_idle();
    HWDATA = d;
    chk({tag, "_rdy"}, 32'(HREADY), 32'd1);
    chk({tag, "_resp"}, 32'(HRESP), 32'(exp_resp));
    step();
    HWDATA = 32'd0;
  endtask

  task automatic bus_rd(input int off, input logic exp_resp, input logic [31:0] exp_data, input string tag);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'(off * 4);
    step();
    bus_idle();
    chk({tag, "_rdy"}, 32'(HREADY), 32'd1);
    chk({tag, "_resp"}, 32'(HRESP), 32'(exp_resp));
    chk({tag, "_data"}, HRDATA, exp_data);
    step();
  endtask

  initial begin
    logic [31:0] cnt_exp [12];
    int hi;
    cnt_exp = '{32'd0, 32'd1, 32'd1, 32'd2, 32'd2, 32'd3, 32'd3, 32'd4, 32'd4, 32'd0, 32'd0, 32'd1};
    Rst = 1'b1;
    HWDATA = 32'd0;
    bus_idle();
    repeat (3) step();
    chk("rst_hready", 32'(HREADY), 32'd0);
    chk("rst_hresp", 32'(HRESP), 32'd0);
    chk("rst_hrdata", HRDATA, 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_pwm", 32'(pwm_o), 32'd0);
    Rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_data", HRDATA, 32'd0);
      chk("idle_ctl", {29'd0, HREADY, HRESP, irq}, 32'd0);
    end

    bus_rd(0, 1'b0, 32'd0, "rv_ctrl");
    bus_rd(1, 1'b0, 32'd0, "rv_presc");
    bus_rd(2, 1'b0, 32'hFFFF_FFFF, "rv_load");
    bus_rd(3, 1'b0, 32'd0, "rv_count");
    bus_rd(4, 1'b0, 32'd0, "rv_status");

    // Periodic count: LOAD=4, PRESC=1 -> tick on every second edge after enable
    bus_wr(2, 32'd4, 1'b0, "w_load4");
    bus_wr(1, 32'd1, 1'b0, "w_presc1");
    bus_wr(0, 32'd3, 1'b0, "w_ctrl3");
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'd12;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 12) bus_idle();
      chk($sformatf("cnt_rdy%0d", k), 32'(HREADY), 32'd1);
      chk($sformatf("cnt_val%0d", k), HRDATA, cnt_exp[k-1]);
      chk($sformatf("cnt_irq%0d", k), 32'(irq), (k >= 11) ? 32'd1 : 32'd0);
    end
    bus_wr(0, 32'd2, 1'b0, "w_ctrl_stop");
    bus_rd(3, 1'b0, 32'd2, "r_count_held");
    bus_rd(4, 1'b0, 32'd1, "r_status_set");
    chk("irq_before_w1c", 32'(irq), 32'd1);
    bus_wr(4, 32'd1, 1'b0, "w_status_w1c");
    step();
    chk("irq_after_w1c", 32'(irq), 32'd0);
    bus_rd(4, 1'b0, 32'd0, "r_status_clr");

    // One-shot: three ticks then EN self-clears with COUNT back at 0
    bus_wr(2, 32'd2, 1'b0, "w_load2");
    bus_wr(1, 32'd0, 1'b0, "w_presc0");
    bus_wr(0, 32'd5, 1'b0, "w_ctrl5");
    repeat (5) step();
    bus_rd(0, 1'b0, 32'd4, "os_ctrl");
    bus_rd(3, 1'b0, 32'd0, "os_count");
    bus_rd(4, 1'b0, 32'd1, "os_status");
    chk("os_irq", 32'(irq), 32'd0);
    bus_wr(4, 32'd1, 1'b0, "os_w1c");

    // Back-to-back write CTRL then read CTRL
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'd0;
    step();
    HWRITE = 1'b0; HWDATA = 32'd1;
    chk("b2b_wr_rdy", 32'(HREADY), 32'd1);
    chk("b2b_wr_resp", 32'(HRESP), 32'd0);
    step();
    bus_idle(); HWDATA = 32'd0;
    chk("b2b_rd_rdy", 32'(HREADY), 32'd1);
    chk("b2b_rd_data", HRDATA, 32'd1);
    step();
    chk("b2b_after_rdy", 32'(HREADY), 32'd0);
    bus_wr(0, 32'd0, 1'b0, "w_ctrl0");
    bus_wr(4, 32'd1, 1'b0, "w_status_clr2");

    // Unmapped offsets and read-only/unused bits
    bus_wr(2, 32'd7, 1'b0, "w_load7");
    bus_rd(6, 1'b1, 32'd0, "r_off6");
    bus_wr(7, 32'hDEAD_BEEF, 1'b1, "w_off7");
    bus_rd(2, 1'b0, 32'd7, "r_load_kept");
    bus_rd(0, 1'b0, 32'd0, "r_ctrl_kept");
    bus_wr(3, 32'h55, 1'b0, "w_count_ro");
    bus_rd(3, 1'b0, 32'd0, "r_count_ro");
    bus_wr(0, 32'hFFFF_FFF8, 1'b0, "w_ctrl_hi");
    bus_rd(0, 1'b0, 32'd0, "r_ctrl_hi");
    bus_wr(1, 32'hFFFF_FFFF, 1'b0, "w_presc_all");
    bus_rd(1, 1'b0, 32'h0000_FFFF, "r_presc_all");
    bus_wr(1, 32'd0, 1'b0, "w_presc_0b");

`ifdef TMR_PWM_EN
    bus_wr(2, 32'd9, 1'b0, "pwm_load9");
    bus_wr(5, 32'd3, 1'b0, "pwm_cmp3");
    bus_rd(5, 1'b0, 32'd3, "pwm_cmp_rd");
    bus_wr(0, 32'd1, 1'b0, "pwm_en");
    repeat (5) step();
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      hi += int'(pwm_o);
    end
    chk("pwm_duty", 32'(hi), 32'd6);
    bus_wr(0, 32'd0, 1'b0, "pwm_dis");
    step();
    chk("pwm_off", 32'(pwm_o), 32'd0);
`else
    hi = 0;
    bus_rd(5, 1'b1, 32'd0, "r_off5_unmapped");
    chk("pwm_tied", 32'(pwm_o) + 32'(hi), 32'd0);
`endif

    // Reset mid data phase with irq active
    bus_wr(2, 32'd0, 1'b0, "w_load0");
    bus_wr(0, 32'd3, 1'b0, "w_ctrl3b");
    repeat (3) step();
    chk("pre_rst_irq", 32'(irq), 32'd1);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'd0;
    step();
    bus_idle();
    chk("pre_rst_rdy", 32'(HREADY), 32'd1);
    chk("pre_rst_data", HRDATA, 32'd3);
    #1 Rst = 1'b1;
    #1;
    chk("mid_rst_rdy", 32'(HREADY), 32'd0);
    chk("mid_rst_resp", 32'(HRESP), 32'd0);
    chk("mid_rst_data", HRDATA, 32'd0);
    chk("mid_rst_irq", 32'(irq), 32'd0);
    chk("mid_rst_pwm", 32'(pwm_o), 32'd0);
    step();
    Rst = 1'b0;
    step();
    bus_rd(2, 1'b0, 32'hFFFF_FFFF, "post_rst_load");
    bus_rd(0, 1'b0, 32'd0, "post_rst_ctrl");
    bus_rd(4, 1'b0, 32'd0, "post_rst_status");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
